// File: rtl/uart_rx_register.sv
// UART receive path: 16x oversampled serial input, 5-8 data bits with optional
// parity, one stop bit, CPU-readable holding register with status/error flags.
module uart_rx_register (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic       tick16,
   input  logic       CSn,
   input  logic       RE,
   input  logic [3:0] dbits,
   input  logic       parity_en,
   input  logic       parity_odd,
   output logic [7:0] data_out,
   output logic       rxready,
   output logic       receiving,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overrun
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t      state, state_n;
   logic        rx_m, rx_s;
   logic [3:0]  cnt;
   logic [2:0]  bitcnt;
   logic [7:0]  shreg;
   logic [2:0]  last_bit;
   logic        par_en_q, par_odd_q, perr_q;
   logic        read;

   logic        go_start, cnt_clr, do_data, do_par, xfer;
   logic [2:0]  dcfg;
   logic [3:0]  dm1;

   assign read      = RE & ~CSn;
   assign receiving = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx_in;
         rx_s <= rx_m;
      end
   end

   // Index of the last data bit, with dbits clamped into 5..8.
   always_comb begin
      dm1  = dbits - 4'd1;
      dcfg = dm1[2:0];
      if (dbits < 4'd5)
         dcfg = 3'd4;
      else if (dbits > 4'd8)
         dcfg = 3'd7;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n  = state;
      go_start = 1'b0;
      cnt_clr  = 1'b0;
      do_data  = 1'b0;
      do_par   = 1'b0;
      xfer     = 1'b0;
      if (tick16) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n  = START;
                  go_start = 1'b1;
                  cnt_clr  = 1'b1;
               end
            end
            START: begin
               if (cnt == 4'd7) begin
                  cnt_clr = 1'b1;
                  state_n = rx_s ? IDLE : DATA;
               end
            end
            DATA: begin
               if (cnt == 4'd15) begin
                  do_data = 1'b1;
                  if (bitcnt == last_bit)
                     state_n = par_en_q ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (cnt == 4'd15) begin
                  do_par  = 1'b1;
                  state_n = STOP;
               end
            end
            STOP: begin
               if (cnt == 4'd15) begin
                  xfer    = 1'b1;
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Frame datapath; bits land at their final index so the result is right-justified.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         bitcnt    <= '0;
         shreg     <= '0;
         last_bit  <= 3'd7;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         perr_q    <= 1'b0;
      end else if (tick16) begin
         cnt <= cnt_clr ? '0 : cnt + 4'd1;
         if (go_start) begin
            bitcnt    <= '0;
            shreg     <= '0;
            last_bit  <= dcfg;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
         end
         if (do_data) begin
            shreg[bitcnt] <= rx_s;
            bitcnt        <= bitcnt + 3'd1;
         end
         if (do_par)
            perr_q <= (^shreg) ^ rx_s ^ par_odd_q;
      end
   end

   // Transfer takes priority over a same-edge read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out    <= '0;
         rxready     <= 1'b0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else if (xfer) begin
         data_out    <= shreg;
         rxready     <= 1'b1;
         parity_err  <= par_en_q & perr_q;
         framing_err <= ~rx_s;
         if (rxready && !read)
            overrun <= 1'b1;
      end else if (read) begin
         rxready <= 1'b0;
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_register.sv
// Directed bench for uart_rx_register: one bit time is 16 ticks of 4 clk = 64 clk.
module tb_uart_rx_register;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic       tick16 = 1'b0;
   logic       CSn;
   logic       RE;
   logic [3:0] dbits;
   logic       parity_en;
   logic       parity_odd;
   logic [7:0] data_out;
   logic       rxready;
   logic       receiving;
   logic       parity_err;
   logic       framing_err;
   logic       overrun;

   int total = 0;
   int bad   = 0;
   logic [1:0] tdiv = 2'd0;

   uart_rx_register dut (
      .clk         (clk),
      .rst         (rst),
      .rx_in       (rx_in),
      .tick16      (tick16),
      .CSn         (CSn),
      .RE          (RE),
      .dbits       (dbits),
      .parity_en   (parity_en),
      .parity_odd  (parity_odd),
      .data_out    (data_out),
      .rxready     (rxready),
      .receiving   (receiving),
      .parity_err  (parity_err),
      .framing_err (framing_err),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tdiv   <= tdiv + 2'd1;
      tick16 <= (tdiv == 2'd3);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int unsigned nb,
                             input logic has_par, input logic pbit, input logic stop_ok);
      rx_in = 1'b0;
      hold(64);
      for (int unsigned i = 0; i < nb; i++) begin
         rx_in = d[i];
         hold(64);
      end
      if (has_par) begin
         rx_in = pbit;
         hold(64);
      end
      if (stop_ok) begin
         rx_in = 1'b1;
         hold(64);
      end else begin
         rx_in = 1'b0;
         hold(40);
         rx_in = 1'b1;
         hold(24);
      end
   endtask

   task automatic do_read();
      CSn = 1'b0;
      RE  = 1'b1;
      @(negedge clk);
      CSn = 1'b1;
      RE  = 1'b0;
   endtask

   task automatic wait_recv(input logic level, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (receiving === level) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Counts tick edges until the chosen condition is seen at a negedge.
   task automatic count_ticks(input bit until_idle, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!until_idle && rxready === 1'b1) begin ok = 1'b1; break; end
         if (until_idle && receiving === 1'b0) begin ok = 1'b1; break; end
         if (tick16) n++;
      end
   endtask

   initial begin
      bit ok;
      int n;

      rst = 1'b1; rx_in = 1'b1; CSn = 1'b1; RE = 1'b0;
      dbits = 4'd8; parity_en = 1'b0; parity_odd = 1'b0;
      hold(3);
      chk("rst_data", data_out, 8'h00);
      chk("rst_rxready", rxready, 1'b0);
      chk("rst_receiving", receiving, 1'b0);
      chk("rst_perr", parity_err, 1'b0);
      chk("rst_ferr", framing_err, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      rst = 1'b0;
      hold(64);

      // 8N1 0xA5 with latency measurement
      fork
         send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
         begin
            wait_recv(1'b1, ok);
            chk("t1_detect", ok, 1'b1);
            count_ticks(1'b0, n, ok);
            chk("t1_ready_seen", ok, 1'b1);
            chk("t1_ticks", n, 152);
            chk("t1_data", data_out, 8'hA5);
            chk("t1_perr", parity_err, 1'b0);
            chk("t1_ferr", framing_err, 1'b0);
            chk("t1_receiving", receiving, 1'b0);
         end
      join
      do_read();
      chk("t1_read_rxready", rxready, 1'b0);
      chk("t1_read_data_kept", data_out, 8'hA5);
      hold(64);

      // 5 data bits, odd parity, 0x13: correct parity bit is 0
      dbits = 4'd5; parity_en = 1'b1; parity_odd = 1'b1;
      send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1);
      chk("t2a_rxready", rxready, 1'b1);
      chk("t2a_data", data_out, 8'h13);
      chk("t2a_perr", parity_err, 1'b0);
      do_read();
      hold(64);
      dbits = 4'd3;
      send_frame(8'h13, 5, 1'b1, 1'b1, 1'b1);
      chk("t2b_data", data_out, 8'h13);
      chk("t2b_perr", parity_err, 1'b1);
      chk("t2b_ferr", framing_err, 1'b0);
      do_read();
      hold(64);

      // 3-tick low glitch on idle line
      fork
         begin
            rx_in = 1'b0;
            hold(12);
            rx_in = 1'b1;
         end
         begin
            wait_recv(1'b1, ok);
            chk("t3_detect", ok, 1'b1);
            count_ticks(1'b1, n, ok);
            chk("t3_idle_seen", ok, 1'b1);
            chk("t3_ticks", n, 8);
         end
      join
      hold(64);
      chk("t3_rxready", rxready, 1'b0);
      chk("t3_perr_kept", parity_err, 1'b1);
      chk("t3_data_kept", data_out, 8'h13);
      chk("t3_overrun", overrun, 1'b0);

      // 8N1 with bad stop, then clean 0x3C with dbits clamped from 12
      dbits = 4'd8; parity_en = 1'b0; parity_odd = 1'b0;
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0);
      chk("t4a_rxready", rxready, 1'b1);
      chk("t4a_ferr", framing_err, 1'b1);
      chk("t4a_data", data_out, 8'h81);
      chk("t4a_perr", parity_err, 1'b0);
      hold(128);
      do_read();
      dbits = 4'd12;
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      chk("t4b_data", data_out, 8'h3C);
      chk("t4b_ferr", framing_err, 1'b0);
      chk("t4b_overrun", overrun, 1'b0);
      do_read();
      hold(64);

      // back-to-back without read
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
      chk("t5_overrun", overrun, 1'b1);
      chk("t5_data", data_out, 8'h22);
      chk("t5_rxready", rxready, 1'b1);
      do_read();
      chk("t5_read_overrun", overrun, 1'b0);
      chk("t5_read_rxready", rxready, 1'b0);
      hold(64);

      // back-to-back with read on the second transfer edge
      fork
         begin
            send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
            send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
         end
         begin
            wait_recv(1'b1, ok);
            chk("t6_f1_start", ok, 1'b1);
            @(negedge clk);
            wait_recv(1'b0, ok);
            chk("t6_f1_end", ok, 1'b1);
            chk("t6_f1_data", data_out, 8'h11);
            wait_recv(1'b1, ok);
            chk("t6_f2_start", ok, 1'b1);
            n = 0;
            for (int k = 0; k < 3000 && n < 152; k++) begin
               @(negedge clk);
               if (tick16) n++;
            end
            chk("t6_tick_budget", n, 152);
            CSn = 1'b0;
            RE  = 1'b1;
            @(negedge clk);
            CSn = 1'b1;
            RE  = 1'b0;
            chk("t6_rxready", rxready, 1'b1);
            chk("t6_overrun", overrun, 1'b0);
            chk("t6_data", data_out, 8'h22);
         end
      join
      hold(64);

      // reset at mid data bit 4, then a clean 0x5A
      rx_in = 1'b0; hold(64);
      rx_in = 1'b1; hold(64);
      rx_in = 1'b0; hold(64);
      rx_in = 1'b1; hold(64);
      rx_in = 1'b1; hold(64);
      rx_in = 1'b1; hold(32);
      chk("t7_busy", receiving, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("t7_data", data_out, 8'h00);
      chk("t7_rxready", rxready, 1'b0);
      chk("t7_receiving", receiving, 1'b0);
      chk("t7_perr", parity_err, 1'b0);
      chk("t7_ferr", framing_err, 1'b0);
      chk("t7_overrun", overrun, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      hold(128);
      chk("t7_idle_rxready", rxready, 1'b0);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
      chk("t7_new_data", data_out, 8'h5A);
      chk("t7_new_rxready", rxready, 1'b1);
      chk("t7_new_ferr", framing_err, 1'b0);
      chk("t7_new_overrun", overrun, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_register.md
# uart_rx_register

Receive side of the UART: samples the serial line at 16x the bit rate, assembles a 5–8 data-bit frame with optional parity and one stop bit, and moves the result into a CPU-readable holding register. A status flag and error flags go to the bus interface. It pairs with the transmit holding register and shifter and shares the same `CSn`/`dbits` register-interface conventions.

## Interface
- No parameters. Oversampling is fixed at 16.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_in` in 1: serial line, idle high. Asynchronous to `clk`.
- `tick16` in 1: one-`clk` strobe at 16x baud.
- `CSn` in 1: chip select, active low.
- `RE` in 1: read enable. `read = RE & ~CSn`.
- `dbits` in 4: data bits per frame. Values below 5 are treated as 5; values above 8 are treated as 8.
- `parity_en` in 1: a parity bit follows the data bits.
- `parity_odd` in 1: 1 selects odd parity, 0 selects even parity.
- `data_out` out 8: received byte, right-justified, with unused upper bits set to 0.
- `rxready` out 1: the holding register contains unread data.
- `receiving` out 1: high while the FSM is not in IDLE.
- `parity_err` out 1: parity status of the frame in the holding register.
- `framing_err` out 1: stop-bit status of the frame in the holding register.
- `overrun` out 1: sticky; a frame arrived while `rxready` was still set.

## Operation
- `rx_in` passes through a 2-FF synchronizer (`rx_s`). Both FFs reset to 1.
- FSM states are IDLE, START, DATA, PARITY, STOP. A 4-bit tick counter `cnt` and a 3-bit bit counter are used.
- All counting and sampling happens only on `clk` edges where `tick16=1`.
- **IDLE**: when `rx_s=0`, go to START with `cnt=0`.
- **START**: when `cnt=7` (mid-bit), check `rx_s`.
  - `rx_s=0`: go to DATA with `cnt=0` and bit counter 0.
  - `rx_s=1`: this is a false start. Return to IDLE with no flags changed.
- **DATA**: when `cnt=15`, sample `rx_s` LSB-first into the shift register and increment the bit counter. After the sample for bit `dbits-1`, go to PARITY if `parity_en`, otherwise go to STOP.
- **PARITY**: when `cnt=15`, sample the parity bit and compute `perr`.
  - Even parity: XOR of the data bits and the parity bit must be 0.
  - Odd parity: that XOR must be 1.
- **STOP**: when `cnt=15`, sample the stop bit and set `ferr = ~rx_s`. Then perform the transfer (below) and go directly to IDLE. Leaving at mid-stop-bit lets back-to-back frames be received.
- **Transfer** happens on one edge:
  - `data_out` is loaded with the frame, right-justified.
  - `rxready` is set to 1.
  - `parity_err` is loaded with `perr`, or 0 if `parity_en=0`.
  - `framing_err` is loaded with `ferr`.
  - If `rxready=1` and `read=0` on that edge, `overrun` is set to 1.
  - The frame is transferred even when it has a framing or parity error.
- **Read**: on an edge with `read=1`, `rxready` and `overrun` clear to 0. `data_out` and the error flags keep their values.
- **Transfer and read on the same edge**: the transfer wins. `rxready` stays 1, `data_out` takes the new value, and `overrun` is neither set nor cleared.
- `dbits`, `parity_en` and `parity_odd` are sampled on entry to START and held for the whole frame. Changing them mid-frame has no effect on that frame.

## Timing
- **Reset**: state is IDLE, and `data_out=0`, `rxready=0`, `receiving=0`, `parity_err=0`, `framing_err=0`, `overrun=0`. A reset in mid-frame aborts the frame without a transfer.
- **Input latency**: 2 `clk` cycles from `rx_in` to `rx_s`. Start detection occurs on the first `tick16` after that.
- **Start validation**: 8 ticks after detection.
- **Data and parity sampling**: each bit is sampled 16 ticks after the previous sample.
- **Frame end**: `rxready` rises on the stop-bit sample edge. For 8N1 this is 8+16·9 = 152 ticks after start detection.
- **`receiving`**: rises on the edge entering START. It falls on the transfer edge or the false-start edge.
- **`read` effect**: takes effect on the next `clk` edge. `rxready` is low in the cycle after that edge.
- **`tick16=0`**: FSM state and counters hold. Only read handling and the synchronizer operate.

## Test plan
- **8N1 frame 0xA5**, `tick16` every 4 clk → `rxready` rises 152 ticks after the start edge with `data_out=0xA5`, both error flags 0 and `receiving` low. A read then gives `rxready=0`.
- **5 bits, odd parity, value 0x13**, with a correct parity bit followed by a frame with a wrong parity bit → `data_out=0x13`. `parity_err` is 0 for the first frame and 1 for the second.
- **Low glitch of 3 ticks on an idle line** → `receiving` pulses for 8 ticks, `rxready` stays 0 and no flags change.
- **8N1 with stop bit driven 0** → `framing_err=1` and `rxready=1`. The next clean 0x3C frame is received with `framing_err=0`.
- **Two back-to-back frames 0x11 and 0x22 with no read** → `overrun=1` and `data_out=0x22`.
- **Repeat with `read` asserted on the second frame's transfer edge** → `overrun=0` and `rxready=1`.
- **`rst` pulsed at mid data bit 4** → all outputs are 0 and the FSM is in IDLE. The following 0x5A frame is received correctly.
